// File: rtl/mem_io_responder_if.sv
// CPU byte bus plus UART TX/RX byte streams seen by the memory/IO responder.
// The slave modport is the responder side; the master modport is the CPU/UART side.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;

  modport slave (
    input  mem_a, mem_wr, mem_dout, tx_ready, rx_valid, rx_data,
    output mem_din, io_buffer_full, tx_valid, tx_data, rx_ready
  );
  modport master (
    output mem_a, mem_wr, mem_dout, tx_ready, rx_valid, rx_data,
    input  mem_din, io_buffer_full, tx_valid, tx_data, rx_ready
  );
endinterface

// File: rtl/mem_io_responder.sv
// Byte RAM plus memory-mapped IO (UART TX FIFO, RX port, cycle counter, stop flag).
// Every cycle is one bus transaction; read data is registered one cycle later.
module mem_io_responder #(
  parameter int RAM_AW    = 17,
  parameter int TXQ_DEPTH = 8
) (
  input  logic               clk_in,
  input  logic               rst_in_n,
  mem_io_responder_if.slave  bus,
  output logic               program_stop,
  output logic               tx_overflow
);
  localparam int PW = $clog2(TXQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TXQ_DEPTH);
  localparam logic [CW-1:0] NEAR_C  = CW'(TXQ_DEPTH - 1);

  logic [7:0]    r_ram [2**RAM_AW];
  logic [7:0]    r_txq [TXQ_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_cnt, r_snap;
  logic [7:0]    r_din;
  logic          r_full;

  logic              w_io, w_rd, w_wr;
  logic [15:0]       w_off;
  logic [RAM_AW-1:0] w_idx;
  logic [7:0]        w_rdata, w_push_data;
  logic              w_push, w_pop, w_accept, w_drop, w_fifo_full;
  logic [CW-1:0]     w_count_nx;
  logic              w_unused;

  assign w_io     = (bus.mem_a[17:16] == 2'b11);
  assign w_off    = bus.mem_a[15:0];
  assign w_idx    = bus.mem_a[RAM_AW-1:0];
  assign w_rd     = !bus.mem_wr;
  assign w_wr     = bus.mem_wr;
  assign w_unused = ^bus.mem_a[31:18];

  assign bus.rx_ready = w_rd && w_io && (w_off == 16'h0000);

  always_comb begin
    w_rdata = r_ram[w_idx];
    if (w_io) begin
      case (w_off)
        16'h0000: w_rdata = bus.rx_valid ? bus.rx_data : 8'h00;
        16'h0004: w_rdata = r_cnt[7:0];
        16'h0005: w_rdata = r_snap[15:8];
        16'h0006: w_rdata = r_snap[23:16];
        16'h0007: w_rdata = r_snap[31:24];
        default:  w_rdata = 8'h00;
      endcase
    end
  end

  // TX push: nonzero data byte, or the stop marker 0x00 from a stop write.
  assign w_push      = w_wr && w_io &&
                       (((w_off == 16'h0000) && (bus.mem_dout != 8'h00)) || (w_off == 16'h0004));
  assign w_push_data = (w_off == 16'h0004) ? 8'h00 : bus.mem_dout;
  assign w_pop       = (r_count != '0) && bus.tx_ready;
  assign w_fifo_full = (r_count == DEPTH_C);
  assign w_accept    = w_push && (!w_fifo_full || w_pop);
  assign w_drop      = w_push && w_fifo_full && !w_pop;
  assign w_count_nx  = r_count + {{(CW-1){1'b0}}, w_accept} - {{(CW-1){1'b0}}, w_pop};

  assign bus.tx_valid       = (r_count != '0);
  assign bus.tx_data        = (r_count != '0) ? r_txq[r_rptr] : 8'h00;
  assign bus.mem_din        = r_din;
  assign bus.io_buffer_full = r_full;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_din        <= '0;
      r_full       <= 1'b0;
      r_count      <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_cnt        <= '0;
      r_snap       <= '0;
      program_stop <= 1'b0;
      tx_overflow  <= 1'b0;
    end else begin
      r_cnt   <= r_cnt + 32'd1;
      r_count <= w_count_nx;
      r_full  <= (w_count_nx >= NEAR_C);
      if (w_rd) r_din <= w_rdata;
      if (w_rd && w_io && (w_off == 16'h0004)) r_snap <= r_cnt;
      if (w_wr && w_io && (w_off == 16'h0004)) program_stop <= 1'b1;
      if (w_drop)   tx_overflow <= 1'b1;
      if (w_accept) r_wptr <= r_wptr + 1'b1;
      if (w_pop)    r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage arrays are not reset; reset held at the edge suppresses writes.
  always_ff @(posedge clk_in) begin
    if (rst_in_n && w_wr && !w_io) r_ram[w_idx] <= bus.mem_dout;
    if (rst_in_n && w_accept)      r_txq[r_wptr] <= w_push_data;
  end
endmodule
